uart_crc_rx: RTL and testbench
==============================

Name: uart_crc_rx

Overview:
- Parametrised UART receive deframer with inline CRC check.
- Frame format:
  - one start bit (0);
  - DATA_W data bits, LSB first;
  - CRC_W CRC bits, LSB first;
  - one stop bit (1).
- Sits between the rx_i pin and the UART register file. Delivers each received word with CRC/framing status through a valid/ready handshake.
- Generalises the fixed 8+8-bit frame path to arbitrary data/CRC widths and a programmable polynomial, and adds false-start rejection and overrun detection.

Parameters:
- DATA_W, 8, data bits per frame (1..32)
- CRC_W, 8, CRC bits per frame (1..16)
- CRC_POLY, 8'h07, generator polynomial with implicit top term, CRC_W bits
- CRC_INIT, 0, CRC register value at start of each frame
- DIV_W, 16, width of baud divisor

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en_i  in  1  receiver enable; 0 holds FSM in IDLE
- baud_div_i  in  DIV_W  bit period = baud_div_i+1 clocks; must be >= 3
- rx_i  in  1  serial input, idle high, asynchronous
- data_o  out  DATA_W  received data word
- crc_err_o  out  1  received CRC != computed CRC, qualified by valid_o
- frame_err_o  out  1  stop bit sampled 0, qualified by valid_o
- valid_o  out  1  output word available
- ready_i  in  1  consumer accepts word when valid_o&&ready_i
- overrun_o  out  1  one-cycle pulse: frame completed while valid_o still high
- busy_o  out  1  FSM not in IDLE

Behaviour:
- **Reset.** All outputs are 0 at reset: data_o, crc_err_o, frame_err_o, valid_o, overrun_o, busy_o.
  - FSM goes to IDLE and counters clear.
  - Synchroniser flops reset to 1.
  - Reset mid-frame aborts the frame; no partial word is ever presented.
- **Input synchroniser.** rx_i passes through 2 flops; all logic uses the synchronised value rx_s.
- **Timing.** Bit counter cnt counts 0..baud_div_i. A sample point is the cycle where cnt == baud_div_i>>1.
  - baud_div_i is latched at the start-bit detect and is constant for the whole frame.
- **FSM states:** IDLE, START, DATA, CRC, STOP.
  - **IDLE:**
    - With en_i=1 and rx_s=0, go to START and set cnt=0.
    - With en_i=0, stay in IDLE regardless of rx_s.
  - **START:**
    - At the sample point, rx_s=1 is a false start: return to IDLE, no output.
    - At the sample point, rx_s=0: continue; subsequent samples occur every baud_div_i+1 clocks.
    - Load crc=CRC_INIT and set bit index=0.
  - **DATA:**
    - Each sample shifts rx_s into the data shift register at bit[idx], LSB first.
    - Each sample also updates the CRC: fb = crc[CRC_W-1]^rx_s; crc = {crc[CRC_W-2:0],0} ^ (fb ? CRC_POLY : 0).
    - After DATA_W samples, go to CRC.
  - **CRC:**
    - Each sample stores rx_s into crc_rx[idx], LSB first. The computed CRC is not updated.
    - After CRC_W samples, go to STOP.
  - **STOP:**
    - At the sample point, finish the frame and go to IDLE in the same cycle, so a start bit is accepted from the next cycle.
    - Frame result: crc_err = (crc_rx != crc), frame_err = !rx_s.
- **Output handshake.**
  - If valid_o=0 at frame finish: on the next edge, valid_o=1 and data_o/crc_err_o/frame_err_o are loaded.
  - Outputs hold until valid_o&&ready_i; valid_o clears on that edge.
  - If valid_o=1 and ready_i=0 at frame finish: the new frame is dropped, existing outputs are unchanged, and overrun_o=1 for one cycle.
  - If ready_i=1 in the same cycle a frame finishes: the handshake completes and the new word loads (valid_o stays 1). No overrun is reported.
- **en_i deasserted mid-frame.** The frame completes normally; en_i is only checked in IDLE.
- **busy_o** = (state != IDLE).

Test Plan:
- **Good frame.** DATA_W=8, CRC_W=8, POLY=07, INIT=0, baud_div_i=15. Send data 0x01, CRC 0x89, stop=1 -> valid_o=1, data_o=0x01, crc_err_o=0, frame_err_o=0. Output appears 1 clock after the stop-bit sample.
- **CRC error.** Same as good frame but CRC 0x88 -> valid_o=1, data_o=0x01, crc_err_o=1, frame_err_o=0. Also send data 0x00, CRC 0x00 -> crc_err_o=0.
- **Framing error.** Data 0x01, CRC 0x89, stop bit driven 0 -> frame_err_o=1, crc_err_o=0, data_o=0x01.
- **Glitch rejection.** rx_i low for 4 clocks with baud_div_i=15 -> busy_o returns to 0 after the start sample, no valid_o. A following good frame 0x01/0x89 is received correctly.
- **Overrun.** ready_i=0; send 0x01/0x89 then 0x00/0x00 back-to-back -> overrun_o pulses once, data_o stays 0x01. Raise ready_i -> valid_o drops next cycle.
- **Reset mid-frame.** Assert rst during the 4th data bit -> all outputs 0 and busy_o=0 next cycle. A subsequent 0x01/0x89 frame is received with no error flags.

Source files
------------

// File: rtl/uart_crc_rx_if.sv
// Handshake bundle between uart_crc_rx and its consumer: the received word,
// its CRC/framing status, and valid/ready.
interface uart_crc_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              crc_err;
    logic              frame_err;
    logic              valid;
    logic              ready;

    modport master (
        output data,
        output crc_err,
        output frame_err,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  crc_err,
        input  frame_err,
        input  valid,
        output ready
    );
endinterface

// File: rtl/uart_crc_rx.sv
// UART receive deframer: start bit, DATA_W data bits, CRC_W CRC bits and a stop bit.
// Checks the CRC inline and hands out each word with its status over valid/ready.
module uart_crc_rx #(
    parameter int unsigned      DATA_W   = 8,
    parameter int unsigned      CRC_W    = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0] CRC_INIT = '0,
    parameter int unsigned      DIV_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic [DIV_W-1:0]    baud_div_i,
    input  logic                rx_i,
    uart_crc_rx_if.master       out_if,
    output logic                overrun_o,
    output logic                busy_o
);

    localparam int unsigned      IDX_W     = 6;
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] CRC_LAST  = IDX_W'(CRC_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_CRC   = 3'd3,
        S_STOP  = 3'd4
    } state_e;

    state_e              state_q;
    logic                rx_meta_q;
    logic                rx_sync_q;
    logic [DIV_W-1:0]    cnt_q;
    logic [DIV_W-1:0]    div_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   shift_q;
    logic [CRC_W-1:0]    crc_q;
    logic [CRC_W-1:0]    crc_rx_q;
    logic                busy_q;

    logic [DATA_W-1:0]   data_q;
    logic                crc_err_q;
    logic                frame_err_q;
    logic                valid_q;
    logic                overrun_q;

    logic                rx_s;
    logic                sample_s;
    logic                finish_s;
    logic                crc_err_s;
    logic                frame_err_s;

    // One serial CRC step: shift left, fold in the polynomial when the feedback bit is set.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic             fb;
        logic [CRC_W-1:0] s;
        fb = c[CRC_W-1] ^ b;
        s  = c << 1;
        return fb ? (s ^ CRC_POLY) : s;
    endfunction

    // LSB-first shift-in: after W samples, bit i holds the i-th received bit.
    function automatic logic [DATA_W-1:0] shift_data(input logic [DATA_W-1:0] v, input logic b);
        logic [DATA_W-1:0] t;
        t           = v >> 1;
        t[DATA_W-1] = b;
        return t;
    endfunction

    function automatic logic [CRC_W-1:0] shift_crc(input logic [CRC_W-1:0] v, input logic b);
        logic [CRC_W-1:0] t;
        t          = v >> 1;
        t[CRC_W-1] = b;
        return t;
    endfunction

    assign rx_s = rx_sync_q;

    // Sample-point decode and end-of-frame status.
    always_comb begin
        sample_s    = (cnt_q == (div_q >> 1));
        finish_s    = (state_q == S_STOP) && sample_s;
        crc_err_s   = (crc_rx_q != crc_q);
        frame_err_s = !rx_s;
    end

    // Two-flop synchroniser for the asynchronous serial pin, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receive FSM with bit timing, data/CRC shift registers and running CRC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            crc_q    <= '0;
            crc_rx_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE || cnt_q == div_q) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (en_i && !rx_s) begin
                        state_q <= S_START;
                        div_q   <= baud_div_i;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (sample_s) begin
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                            crc_q   <= CRC_INIT;
                            idx_q   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_s) begin
                        shift_q <= shift_data(shift_q, rx_s);
                        crc_q   <= crc_step(crc_q, rx_s);
                        if (idx_q == DATA_LAST) begin
                            state_q <= S_CRC;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                S_CRC: begin
                    if (sample_s) begin
                        crc_rx_q <= shift_crc(crc_rx_q, rx_s);
                        if (idx_q == CRC_LAST) begin
                            state_q <= S_STOP;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                S_STOP: begin
                    // Leave on the stop sample so a start bit is seen from the next cycle.
                    if (sample_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register with valid/ready handshake and overrun reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (finish_s && (!valid_q || out_if.ready)) begin
                data_q      <= shift_q;
                crc_err_q   <= crc_err_s;
                frame_err_q <= frame_err_s;
                valid_q     <= 1'b1;
            end else if (finish_s) begin
                overrun_q <= 1'b1;
            end else if (valid_q && out_if.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_if.data      = data_q;
    assign out_if.crc_err   = crc_err_q;
    assign out_if.frame_err = frame_err_q;
    assign out_if.valid     = valid_q;
    assign overrun_o        = overrun_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_uart_crc_rx.sv
// Self-checking bench for uart_crc_rx: directed frames plus randomized frames
// compared against a polynomial-division CRC model and an expected-word queue.
module tb_uart_crc_rx;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        en_i       = 1'b1;
    logic        rx_i       = 1'b1;
    logic [15:0] baud_div_i = 16'd15;
    logic        overrun_o;
    logic        busy_o;

    int          checks    = 0;
    int          errors    = 0;
    int          got_cnt   = 0;
    int          ovr_cnt   = 0;
    bit          busy_seen = 1'b0;
    logic [9:0]  exp_q[$];

    uart_crc_rx_if #(.DATA_W(8)) rx_if();

    uart_crc_rx #(
        .DATA_W  (8),
        .CRC_W   (8),
        .CRC_POLY(8'h07),
        .CRC_INIT(8'h00),
        .DIV_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_i),
        .baud_div_i(baud_div_i),
        .rx_i      (rx_i),
        .out_if    (rx_if),
        .overrun_o (overrun_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // CRC as remainder of M(x)*x^8 mod (x^8+x^2+x+1); the first bit on the wire is the top term of M.
    function automatic logic [7:0] ref_crc(input logic [7:0] d);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) m = m | (32'd1 << (7 - i));
        end
        m = m << 8;
        for (int i = 15; i >= 8; i--) begin
            if (m[i]) m = m ^ (32'h107 << (i - 8));
        end
        return m[7:0];
    endfunction

    // Every accepted word is popped from the expected queue and compared.
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst) begin
            if (busy_o) busy_seen = 1'b1;
            if (overrun_o) ovr_cnt++;
            if (rx_if.valid && rx_if.ready) begin
                got_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("queue_nonempty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("data", 32'(rx_if.data), 32'(e[7:0]));
                    check_eq("crc_err", 32'(rx_if.crc_err), 32'(e[8]));
                    check_eq("frame_err", 32'(rx_if.frame_err), 32'(e[9]));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        tick(int'(baud_div_i) + 1);
    endtask

    task automatic idle_gap();
        rx_i = 1'b1;
        tick(2 * (int'(baud_div_i) + 1) + 4);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [7:0] c, input logic stop,
                              input bit expect_out, input bit drop_en);
        int got0;
        if (expect_out) exp_q.push_back({~stop, (c != ref_crc(d)), d});
        send_bit(1'b0);
        if (drop_en) en_i = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        for (int i = 0; i < 8; i++) send_bit(c[i]);
        got0 = got_cnt;
        send_bit(stop);
        en_i = 1'b1;
        if (expect_out && rx_if.ready) begin
            for (int i = 0; i < 2 * (int'(baud_div_i) + 1) && got_cnt == got0; i++) tick(1);
            check_eq("deliver", 32'(got_cnt - got0), 32'd1);
        end
    endtask

    initial begin
        int got0;
        int ovr0;
        logic [7:0] d;
        logic [7:0] c;
        logic       stop;

        rx_if.ready = 1'b1;
        tick(4);
        @(negedge clk);
        check_eq("rst_valid", 32'(rx_if.valid), 32'd0);
        check_eq("rst_data", 32'(rx_if.data), 32'd0);
        check_eq("rst_crc_err", 32'(rx_if.crc_err), 32'd0);
        check_eq("rst_frame_err", 32'(rx_if.frame_err), 32'd0);
        check_eq("rst_overrun", 32'(overrun_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(5);

        // Good, CRC-error, zero and framing-error frames.
        send_frame(8'h01, 8'h89, 1'b1, 1'b1, 1'b0);
        idle_gap();
        send_frame(8'h01, 8'h88, 1'b1, 1'b1, 1'b0);
        idle_gap();
        send_frame(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        idle_gap();
        send_frame(8'h01, 8'h89, 1'b0, 1'b1, 1'b0);
        idle_gap();

        // A 4-clock low pulse is a false start and must produce no word.
        got0      = got_cnt;
        busy_seen = 1'b0;
        rx_i      = 1'b0;
        tick(4);
        rx_i = 1'b1;
        tick(24);
        @(negedge clk);
        check_eq("glitch_busy", 32'(busy_o), 32'd0);
        check_eq("glitch_started", 32'(busy_seen), 32'd1);
        check_eq("glitch_no_word", 32'(got_cnt - got0), 32'd0);
        @(posedge clk);
        #1;
        send_frame(8'h01, 8'h89, 1'b1, 1'b1, 1'b0);
        idle_gap();

        // Overrun: consumer stalled while a second frame arrives back-to-back.
        rx_if.ready = 1'b0;
        ovr0        = ovr_cnt;
        got0        = got_cnt;
        send_frame(8'h01, 8'h89, 1'b1, 1'b1, 1'b0);
        send_frame(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        rx_i = 1'b1;
        tick(20);
        @(negedge clk);
        check_eq("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
        check_eq("ovr_data_hold", 32'(rx_if.data), 32'h01);
        check_eq("ovr_valid_hold", 32'(rx_if.valid), 32'd1);
        @(posedge clk);
        #1;
        rx_if.ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("ovr_valid_drop", 32'(rx_if.valid), 32'd0);
        check_eq("ovr_one_word", 32'(got_cnt - got0), 32'd1);
        @(posedge clk);
        #1;
        idle_gap();

        // Reset during the 4th data bit aborts the frame and clears all outputs.
        @(negedge clk);
        check_eq("pre_rst_data", 32'(rx_if.data), 32'h01);
        @(posedge clk);
        #1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rx_i = 1'b0;
        tick(8);
        @(negedge clk);
        check_eq("midrst_busy_before", 32'(busy_o), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        check_eq("midrst_valid", 32'(rx_if.valid), 32'd0);
        check_eq("midrst_data", 32'(rx_if.data), 32'd0);
        check_eq("midrst_flags", 32'({rx_if.crc_err, rx_if.frame_err, overrun_o}), 32'd0);
        check_eq("midrst_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_gap();
        send_frame(8'h01, 8'h89, 1'b1, 1'b1, 1'b0);
        idle_gap();

        // Receiver disabled: a full frame must be ignored.
        en_i      = 1'b0;
        busy_seen = 1'b0;
        got0      = got_cnt;
        send_frame(8'h5A, ref_crc(8'h5A), 1'b1, 1'b0, 1'b0);
        en_i = 1'b0;
        idle_gap();
        @(negedge clk);
        check_eq("dis_busy", 32'(busy_seen), 32'd0);
        check_eq("dis_no_word", 32'(got_cnt - got0), 32'd0);
        @(posedge clk);
        #1;
        en_i = 1'b1;
        idle_gap();

        // Randomized frames, baud rates, corruptions and mid-frame enable drops.
        for (int n = 0; n < 40; n++) begin
            baud_div_i = 16'($urandom_range(3, 20));
            idle_gap();
            d    = 8'($urandom);
            c    = ref_crc(d);
            if ($urandom_range(0, 2) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, c, stop, 1'b1, ($urandom_range(0, 3) == 0));
            idle_gap();
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        check_eq("drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
